// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory access per load/store, stalls
// the pipeline until completion, formats load data and reports exceptions.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_mem_read/write      access request from EX/MEM (both high = write)
//   in_reg_write           register write enable from EX/MEM
//   in_mem_to_reg          writeback source select from EX/MEM
//   in_rd                  destination register index
//   in_alu_result          effective byte address or ALU result
//   in_store_data          store source, data right-justified
//   in_funct3              access size/sign (111 illegal)
//   dmem_req/we/addr       memory request, write enable, aligned address
//   dmem_wdata/wstrb       lane-shifted store data and byte strobes
//   dmem_ready/rdata       completion and read doubleword
//   stall                  freezes EX/MEM and MEM/WB registers
//   out_*                  bundle towards the MEM/WB register
//   out_exc/out_exc_code   one-cycle exception pulse (01 misaligned, 10 timeout)

module mem_stage #(
    parameter int BUS_WIDTH   = 64,
    parameter int REGFILE_LEN = 6,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_mem_read,
    input  logic                   in_mem_write,
    input  logic                   in_reg_write,
    input  logic                   in_mem_to_reg,
    input  logic [REGFILE_LEN-1:0] in_rd,
    input  logic [BUS_WIDTH-1:0]   in_alu_result,
    input  logic [BUS_WIDTH-1:0]   in_store_data,
    input  logic [2:0]             in_funct3,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [BUS_WIDTH-1:0]   dmem_addr,
    output logic [BUS_WIDTH-1:0]   dmem_wdata,
    output logic [7:0]             dmem_wstrb,
    input  logic                   dmem_ready,
    input  logic [BUS_WIDTH-1:0]   dmem_rdata,
    output logic                   stall,
    output logic                   out_reg_write,
    output logic                   out_mem_to_reg,
    output logic [REGFILE_LEN-1:0] out_rd,
    output logic [BUS_WIDTH-1:0]   out_mem_out,
    output logic [BUS_WIDTH-1:0]   out_write_data,
    output logic                   out_exc,
    output logic [1:0]             out_exc_code
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic [BUS_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic [7:0]           wstrb_q;
    logic                 we_q;
    logic [2:0]           funct3_q;
    logic [2:0]           lane_q;

    logic                 access;
    logic                 misaligned;
    logic [2:0]           lane;
    logic [BUS_WIDTH-1:0] size_mask;
    logic [7:0]           strb_base;
    logic [BUS_WIDTH-1:0] wdata_n;
    logic [7:0]           wstrb_n;
    logic                 timeout_hit;

    // Extract the addressed element from the doubleword and extend it.
    function automatic logic [63:0] load_fmt(
        input logic [63:0] rd,
        input logic [2:0]  f3,
        input logic [2:0]  ln
    );
        logic [63:0] s;
        s = rd >> {ln, 3'b000};
        case (f3)
            3'b000:  load_fmt = {{56{s[7]}}, s[7:0]};
            3'b001:  load_fmt = {{48{s[15]}}, s[15:0]};
            3'b010:  load_fmt = {{32{s[31]}}, s[31:0]};
            3'b100:  load_fmt = {56'd0, s[7:0]};
            3'b101:  load_fmt = {48'd0, s[15:0]};
            3'b110:  load_fmt = {32'd0, s[31:0]};
            default: load_fmt = s;
        endcase
    endfunction

    assign access      = in_mem_read | in_mem_write;
    assign lane        = in_alu_result[2:0];
    assign timeout_hit = (count == CW'(TIMEOUT - 1));

    // funct3 111 shares the doubleword size code, so it is flagged separately.
    always_comb begin
        misaligned = 1'b0;
        size_mask  = '1;
        strb_base  = 8'hFF;
        case (in_funct3[1:0])
            2'b00: begin
                size_mask = 64'h0000_0000_0000_00FF;
                strb_base = 8'h01;
            end
            2'b01: begin
                misaligned = lane[0];
                size_mask  = 64'h0000_0000_0000_FFFF;
                strb_base  = 8'h03;
            end
            2'b10: begin
                misaligned = |lane[1:0];
                size_mask  = 64'h0000_0000_FFFF_FFFF;
                strb_base  = 8'h0F;
            end
            default: begin
                misaligned = |lane;
            end
        endcase
        if (in_funct3 == 3'b111) begin
            misaligned = 1'b1;
        end
        misaligned = misaligned & access;
        wdata_n    = (in_store_data & size_mask) << {lane, 3'b000};
        wstrb_n    = strb_base << lane;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            lane_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !misaligned) begin
                        state    <= BUSY;
                        count    <= '0;
                        addr_q   <= {in_alu_result[BUS_WIDTH-1:3], 3'b000};
                        wdata_q  <= wdata_n;
                        wstrb_q  <= wstrb_n;
                        we_q     <= in_mem_write;
                        funct3_q <= in_funct3;
                        lane_q   <= lane;
                    end
                end
                BUSY: begin
                    if (dmem_ready || timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall          = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = addr_q;
        dmem_wdata     = wdata_q;
        dmem_wstrb     = '0;
        out_reg_write  = in_reg_write;
        out_mem_to_reg = in_mem_to_reg;
        out_rd         = in_rd;
        out_mem_out    = '0;
        out_write_data = in_alu_result;
        out_exc        = 1'b0;
        out_exc_code   = 2'b00;
        if (rst) begin
            out_reg_write = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (misaligned) begin
                        out_reg_write = 1'b0;
                        out_exc       = 1'b1;
                        out_exc_code  = 2'b01;
                    end else if (access) begin
                        stall = 1'b1;
                    end
                end
                BUSY: begin
                    dmem_req   = 1'b1;
                    dmem_we    = we_q;
                    dmem_wstrb = wstrb_q;
                    if (dmem_ready) begin
                        if (!we_q) begin
                            out_mem_out = load_fmt(dmem_rdata, funct3_q, lane_q);
                        end
                    end else if (timeout_hit) begin
                        out_reg_write = 1'b0;
                        out_exc       = 1'b1;
                        out_exc_code  = 2'b10;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, timeout and
// reset sequences, then random accesses against a byte-level reference model.

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg;
    logic [5:0]  in_rd;
    logic [63:0] in_alu_result, in_store_data;
    logic [2:0]  in_funct3;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [63:0] dmem_rdata;
    logic        stall, out_reg_write, out_mem_to_reg;
    logic [5:0]  out_rd;
    logic [63:0] out_mem_out, out_write_data;
    logic        out_exc;
    logic [1:0]  out_exc_code;

    int passes = 0;
    int total  = 0;

    mem_stage #(.BUS_WIDTH(64), .REGFILE_LEN(6), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_rd(in_rd), .in_alu_result(in_alu_result),
        .in_store_data(in_store_data), .in_funct3(in_funct3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall(stall), .out_reg_write(out_reg_write),
        .out_mem_to_reg(out_mem_to_reg), .out_rd(out_rd),
        .out_mem_out(out_mem_out), .out_write_data(out_write_data),
        .out_exc(out_exc), .out_exc_code(out_exc_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] rdata;
        int          waits;
        logic        exc;
        logic [63:0] out;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drop_inputs();
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_reg_write  = 1'b0;
        in_mem_to_reg = 1'b0;
        in_funct3     = 3'b000;
        in_alu_result = 64'd0;
        in_store_data = 64'd0;
        dmem_ready    = 1'b0;
    endtask

    // Reference: byte-by-byte view of the access rules.
    function automatic vec_t model(input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [63:0] addr,
                                   input logic [63:0] sdata,
                                   input logic [63:0] rdata, input int waits);
        vec_t v;
        int size, ln;
        size    = 1 << f3[1:0];
        ln      = int'(addr[2:0]);
        v.rd    = rd;    v.wr    = wr;    v.f3 = f3;
        v.addr  = addr;  v.sdata = sdata; v.rdata = rdata;
        v.waits = waits;
        v.exc   = (f3 == 3'b111) || (ln % size != 0);
        v.out   = 64'd0;
        v.strb  = 8'd0;
        v.wdata = 64'd0;
        if (!v.exc) begin
            for (int k = 0; k < size; k++) begin
                v.strb[ln + k]          = 1'b1;
                v.wdata[8*(ln+k) +: 8]  = sdata[8*k +: 8];
                v.out[8*k +: 8]         = rdata[8*(ln+k) +: 8];
            end
            if (!f3[2] && size < 8 && v.out[8*size-1])
                for (int k = size; k < 8; k++) v.out[8*k +: 8] = 8'hFF;
            if (wr) v.out = 64'd0;
        end
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        logic [63:0] mask;
        int stalls;
        logic exp_rw;
        exp_rw = v.rd & ~v.wr;
        mask   = 64'd0;
        for (int k = 0; k < 8; k++)
            if (v.strb[k]) mask[8*k +: 8] = 8'hFF;
        @(negedge clk);
        in_mem_read   = v.rd;
        in_mem_write  = v.wr;
        in_funct3     = v.f3;
        in_alu_result = v.addr;
        in_store_data = v.sdata;
        in_reg_write  = exp_rw;
        in_mem_to_reg = exp_rw;
        in_rd         = 6'd17;
        dmem_rdata    = v.rdata;
        dmem_ready    = 1'b0;
        #1;
        if (v.exc) begin
            check({tag, " exc"}, 64'(out_exc), 64'd1);
            check({tag, " exc_code"}, 64'(out_exc_code), 64'd1);
            check({tag, " exc_stall"}, 64'(stall), 64'd0);
            check({tag, " exc_regwr"}, 64'(out_reg_write), 64'd0);
            check({tag, " exc_req"}, 64'(dmem_req), 64'd0);
        end else begin
            stalls = 0;
            if (stall) stalls++;
            check({tag, " idle_req"}, 64'(dmem_req), 64'd0);
            for (int i = 0; i <= v.waits; i++) begin
                @(negedge clk);
                dmem_ready = (i == v.waits);
                #1;
                if (stall) stalls++;
                check({tag, " req"}, 64'(dmem_req), 64'd1);
                check({tag, " addr"}, dmem_addr, {v.addr[63:3], 3'b000});
                check({tag, " we"}, 64'(dmem_we), 64'(v.wr));
                if (i == v.waits) begin
                    check({tag, " mem_out"}, out_mem_out, v.out);
                    check({tag, " done_exc"}, 64'(out_exc), 64'd0);
                    check({tag, " regwr"}, 64'(out_reg_write), 64'(exp_rw));
                    check({tag, " rd"}, 64'(out_rd), 64'd17);
                    if (v.wr) begin
                        check({tag, " wstrb"}, 64'(dmem_wstrb), 64'(v.strb));
                        check({tag, " wdata"}, dmem_wdata & mask, v.wdata);
                    end
                end
            end
            check({tag, " stall_cycles"}, 64'(stalls), 64'(v.waits + 1));
        end
        @(negedge clk);
        drop_inputs();
        #1;
        check({tag, " after_req"}, 64'(dmem_req), 64'd0);
        check({tag, " after_stall"}, 64'(stall), 64'd0);
    endtask

    vec_t table_v[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        table_v = '{
            '{1,0,3'b000,64'h1003,64'h0,64'h0000_0000_8000_0000,3,0,
              64'hFFFF_FFFF_FFFF_FF80,8'h00,64'h0},
            '{0,1,3'b001,64'h2006,64'hBEEF,64'h0,0,0,
              64'h0,8'hC0,64'hBEEF_0000_0000_0000},
            '{1,0,3'b010,64'h3002,64'h0,64'h0,0,1,64'h0,8'h00,64'h0},
            '{1,0,3'b101,64'h1006,64'h0,64'h8001_0000_0000_0000,1,0,
              64'h8001,8'h00,64'h0},
            '{1,0,3'b011,64'h4008,64'h0,64'h0123_4567_89AB_CDEF,1,0,
              64'h0123_4567_89AB_CDEF,8'h00,64'h0},
            '{1,1,3'b000,64'h7005,64'hFFFF_FFFF_FFFF_FFAB,64'h0,2,0,
              64'h0,8'h20,64'h0000_AB00_0000_0000},
            '{0,1,3'b011,64'h8003,64'h0,64'h0,0,1,64'h0,8'h00,64'h0},
            '{1,0,3'b111,64'h8000,64'h0,64'h0,0,1,64'h0,8'h00,64'h0},
            '{1,0,3'b001,64'h2001,64'h0,64'h0,0,1,64'h0,8'h00,64'h0},
            '{1,0,3'b110,64'h9004,64'h0,64'hF000_0000_0000_0000,0,0,
              64'h0000_0000_F000_0000,8'h00,64'h0},
            '{1,0,3'b010,64'h9004,64'h0,64'hF000_0000_0000_0000,0,0,
              64'hFFFF_FFFF_F000_0000,8'h00,64'h0},
            '{0,1,3'b010,64'hA004,64'h1122_3344,64'h0,1,0,
              64'h0,8'hF0,64'h1122_3344_0000_0000},
            '{1,0,3'b100,64'h1001,64'h0,64'h0000_0000_0000_FF00,0,0,
              64'hFF,8'h00,64'h0},
            '{0,1,3'b011,64'hB000,64'hDEAD_BEEF_CAFE_F00D,64'h0,0,0,
              64'h0,8'hFF,64'hDEAD_BEEF_CAFE_F00D}
        };

        // Reset with an access pending: outputs must stay quiet.
        rst           = 1'b1;
        drop_inputs();
        in_rd         = 6'd0;
        dmem_rdata    = 64'd0;
        in_mem_read   = 1'b1;
        in_reg_write  = 1'b1;
        in_funct3     = 3'b011;
        in_alu_result = 64'h4000;
        #1;
        check("rst stall", 64'(stall), 64'd0);
        check("rst req", 64'(dmem_req), 64'd0);
        check("rst we", 64'(dmem_we), 64'd0);
        check("rst wstrb", 64'(dmem_wstrb), 64'd0);
        check("rst regwr", 64'(out_reg_write), 64'd0);
        check("rst exc", 64'(out_exc), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drop_inputs();

        // Plain ALU op passes through without touching memory.
        in_alu_result = 64'h10;
        in_reg_write  = 1'b1;
        in_rd         = 6'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("alu stall", 64'(stall), 64'd0);
            check("alu wdata", out_write_data, 64'h10);
            check("alu memout", out_mem_out, 64'd0);
            check("alu req", 64'(dmem_req), 64'd0);
            check("alu regwr", 64'(out_reg_write), 64'd1);
            check("alu rd", 64'(out_rd), 64'd9);
            @(negedge clk);
        end
        drop_inputs();

        foreach (table_v[i]) run_txn(table_v[i], $sformatf("vec%0d", i));

        // LD with ready held low: abort in the sixteenth BUSY cycle.
        @(negedge clk);
        in_mem_read   = 1'b1;
        in_reg_write  = 1'b1;
        in_funct3     = 3'b011;
        in_alu_result = 64'h4000;
        #1;
        check("to idle_stall", 64'(stall), 64'd1);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("to req%0d", i), 64'(dmem_req), 64'd1);
            if (i < 16) begin
                check($sformatf("to stall%0d", i), 64'(stall), 64'd1);
                check($sformatf("to noexc%0d", i), 64'(out_exc), 64'd0);
            end else begin
                check("to stall_end", 64'(stall), 64'd0);
                check("to exc", 64'(out_exc), 64'd1);
                check("to code", 64'(out_exc_code), 64'd2);
                check("to regwr", 64'(out_reg_write), 64'd0);
            end
        end
        @(negedge clk);
        drop_inputs();
        #1;
        check("to after_req", 64'(dmem_req), 64'd0);
        check("to after_exc", 64'(out_exc), 64'd0);

        // Reset in the second BUSY cycle abandons the load.
        @(negedge clk);
        in_mem_read   = 1'b1;
        in_reg_write  = 1'b1;
        in_funct3     = 3'b010;
        in_alu_result = 64'h5000;
        #1;
        check("rb idle_stall", 64'(stall), 64'd1);
        @(negedge clk);
        #1;
        check("rb busy1_req", 64'(dmem_req), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rb rst_req", 64'(dmem_req), 64'd0);
        check("rb rst_stall", 64'(stall), 64'd0);
        check("rb rst_exc", 64'(out_exc), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drop_inputs();
        #1;
        check("rb next_req", 64'(dmem_req), 64'd0);
        check("rb next_stall", 64'(stall), 64'd0);
        check("rb next_exc", 64'(out_exc), 64'd0);
        check("rb next_memout", out_mem_out, 64'd0);

        // Random accesses against the reference model.
        for (int n = 0; n < 80; n++) begin
            logic rd, wr;
            logic [2:0] f3;
            logic [63:0] addr, sd, rdt;
            wr   = 1'($urandom_range(0, 1));
            rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            f3   = 3'($urandom_range(0, 7));
            addr = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) != 0) addr[2:0] = 3'b000;
            sd   = {32'($urandom), 32'($urandom)};
            rdt  = {32'($urandom), 32'($urandom)};
            run_txn(model(rd, wr, f3, addr, sd, rdt, $urandom_range(0, 4)),
                    $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
- REQ-001 SHALL have parameter BUS_WIDTH, default 64, data/address width (fixed at 64; byte-lane logic assumes 8 lanes).
- REQ-002 SHALL have parameter REGFILE_LEN, default 6, destination register index width.
- REQ-003 SHALL have parameter TIMEOUT, default 16, maximum BUSY cycles before abort.
- REQ-004 clk  in  1  clock; all state updates on rising edge.
- REQ-005 rst  in  1  synchronous, active-high reset.
- REQ-006 in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg  in  1 each  control from EX/MEM register.
- REQ-007 in_rd  in  REGFILE_LEN  destination register.
- REQ-008 in_alu_result  in  64  effective byte address / ALU result.
- REQ-009 in_store_data  in  64  store source, data in bits [n-1:0].
- REQ-010 in_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
- REQ-011 dmem_req, dmem_we  out  1 each  memory request / write enable.
- REQ-012 dmem_addr  out  64  doubleword-aligned address (in_alu_result with [2:0] cleared).
- REQ-013 dmem_wdata  out  64 and dmem_wstrb  out  8  lane-shifted store data and byte strobes.
- REQ-014 dmem_ready  in  1 and dmem_rdata  in  64  completion and 64-bit read doubleword.
- REQ-015 stall  out  1  freezes EX/MEM and MEM/WB registers when high.
- REQ-016 out_reg_write, out_mem_to_reg, out_rd, out_mem_out (64), out_write_data (64)  out  to MEM/WB register.
- REQ-017 out_exc  out  1 and out_exc_code  out  2  (01 misaligned/illegal, 10 bus timeout), one-cycle pulse.

Function
- REQ-018 FSM states IDLE, BUSY.
- REQ-019 Access = in_mem_read | in_mem_write (both high: treat as write).
- REQ-020 Misaligned when H and addr[0]!=0, W and addr[1:0]!=0, D and addr[2:0]!=0, or funct3=111 on an access.
- REQ-021 IDLE, no access: stall=0, outputs pass through; out_write_data=in_alu_result, out_mem_out=0.
- REQ-022 IDLE, aligned access: stall=1, latch address, we, funct3, lane wdata, wstrb; next state BUSY; counter cleared.
- REQ-023 IDLE, misaligned access: no request, stall=0, out_reg_write=0, out_exc=1, out_exc_code=01, stay IDLE.
- REQ-024 BUSY: dmem_req=1, dmem_addr/we/wdata/wstrb driven from latches and stable until completion.
- REQ-025 BUSY, dmem_ready=1: stall=0, out_mem_out=formatted load (0 for stores), next state IDLE.
- REQ-026 BUSY, dmem_ready=0: stall=1, counter increments; at counter=TIMEOUT-1 without ready: stall=0, out_reg_write=0, out_exc=1, code 10, next IDLE.
- REQ-027 Minimum access latency 2 cycles (IDLE detect + BUSY with ready); back-to-back accesses re-enter BUSY after one IDLE cycle.
- REQ-028 Load format: lane = addr[2:0]; extract byte/half/word/double at lane*8; sign-extend B/H/W, zero-extend BU/HU/WU.
- REQ-029 Store: data replicated/shifted to lane; wstrb B=1<<lane, H=3<<lane, W=0x0F<<lane, D=0xFF.
- REQ-030 dmem_req=0 and dmem_we=0 whenever not BUSY.
- REQ-031 out_rd, out_mem_to_reg pass through unchanged in all states.

Reset
- REQ-032 rst SHALL force state IDLE, counter 0, latches 0; same cycle drives stall=0, dmem_req=0, dmem_we=0, dmem_wstrb=0, out_reg_write=0, out_exc=0.
- REQ-033 rst during BUSY SHALL abandon the access without completion output or exception; dmem_req low from the next cycle.

Verification
- REQ-034 ALU op, addr 0x10, no access -> stall=0, out_write_data=0x10, dmem_req never high.
- REQ-035 LB addr 0x1003, dmem_rdata 0x00000000_80000000 with ready after 3 BUSY cycles -> dmem_addr 0x1000, stall high 4 cycles, out_mem_out 0xFFFFFFFF_FFFFFF80.
- REQ-036 SH addr 0x2006, data 0xBEEF -> dmem_wstrb 0xC0, dmem_wdata[63:48]=0xBEEF, dmem_we=1, out_mem_out=0.
- REQ-037 LW addr 0x3002 -> no dmem_req, out_exc=1 code 01, out_reg_write=0, stall=0.
- REQ-038 LD addr 0x4000, dmem_ready held low -> abort after TIMEOUT BUSY cycles, out_exc code 10, state IDLE.
- REQ-039 rst asserted in 2nd BUSY cycle of a load -> next cycle dmem_req=0, stall=0, no out_exc.
